spdif_sample_fifo: RTL and testbench
====================================

Name: spdif_sample_fifo

Overview:
- Upstream feeder for the SPDIF transmitter core. Buffers 32-bit stereo samples (R in [31:16], L in [15:0]) pushed by a DMA or audio source over a valid/ready interface.
- Presents one registered "next sample" word to the transmitter and advances it on each single-cycle sample request.
- On underrun it mutes (sends zero) and counts the event. It also provides a low-watermark flag for refill requests.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO entries (16 entries); legal range 2..8.
- LOW_THRESHOLD, 4, low_o asserts when level_o <= this value; must be < 2**DEPTH_LOG2.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  1 = normal operation; 0 = requests are serviced with zero and do not pop or count.
- flush_i  in  1  synchronous clear of FIFO contents and the next-sample register.
- push_valid_i  in  1  source has a sample.
- push_data_i  in  32  {right[15:0], left[15:0]}.
- push_ready_o  out  1  FIFO can accept a sample this cycle.
- sample_o  out  32  registered next sample for the transmitter.
- sample_req_i  in  1  single-cycle pulse from the transmitter: sample_o has been consumed.
- level_o  out  DEPTH_LOG2+1  FIFO occupancy, 0..2**DEPTH_LOG2; excludes the sample_o register.
- low_o  out  1  level_o <= LOW_THRESHOLD.
- underrun_o  out  1  sticky underrun flag.
- underrun_cnt_o  out  16  saturating underrun event count.
- underrun_clr_i  in  1  clears underrun_o and underrun_cnt_o.

Behaviour:
- Reset values: storage pointers 0, level_o 0, sample_o 0, underrun_o 0, underrun_cnt_o 0. push_ready_o follows level, so it is 1 after reset. low_o is 1 after reset.
- Storage: circular buffer of 2**DEPTH_LOG2 x 32 bits. Read/write pointers are DEPTH_LOG2 bits wide and wrap modulo depth. A separate occupancy counter is DEPTH_LOG2+1 bits.
- Push: accepted when push_valid_i && push_ready_o && !flush_i.
  - push_ready_o = !full && !flush_i, decoded from registered level.
  - When full, push_ready_o stays 0 even if a pop happens in the same cycle; no same-cycle full bypass.
- Pop on sample_req_i (enable_i=1, !flush_i):
  - Non-empty: sample_o <= head entry, rd_ptr++, level--. sample_o updates on the cycle after the request (1-cycle latency).
  - Empty (underrun): sample_o <= 0 (mute), underrun_o <= 1, underrun_cnt_o increments and saturates at 16'hFFFF.
  - The transmitter samples sample_o at its subframe load, one cycle before its request pulse. The word it takes is always the one loaded at the previous request. Minimum spacing between requests is 64 bit-enable periods, so no back-to-back requests need support. Consecutive-cycle requests must still behave correctly as two pops.
- Simultaneous push and pop:
  - Non-empty: both occur, level unchanged, pointers both advance.
  - Empty: counts as underrun (no bypass); the pushed word is stored and level becomes 1.
- enable_i=0: a request loads sample_o <= 0 with no pop, no underrun count. Pushes are still accepted.
- flush_i=1 (highest priority): pointers and level clear to 0 and sample_o <= 0. Same-cycle push and pop are ignored. Underrun state is not affected.
- underrun_clr_i is applied before the increment, so clear plus underrun in the same cycle leaves flag=1 and count=1.
- Async reset mid-operation returns everything to reset values immediately; no partial pops.

Decomposition:
- Shared package spdif_pkg:
  - SPDIF_SAMPLE_W=32 and SPDIF_CH_W=16.
  - Channel field positions (R=[31:16], L=[15:0]).
  - Mute value 32'h0.
- One sub-module, spdif_fifo_ram: simple dual-port 2**DEPTH_LOG2 x 32 storage (write port plus asynchronous read at rd_ptr), so the memory can be swapped for a vendor primitive. Pointer, level and control logic stays in spdif_sample_fifo.

Test Plan:
- Reset, then push 3 words 32'h1111_0001..32'h1111_0003 → level_o=3, sample_o=0. Three requests → sample_o reads 0001, 0002, 0003, each one cycle after its request; level_o=0; underrun_o=0.
- Push 16 words with no requests → push_ready_o=0 after the 16th; level_o=16; a 17th push is not accepted. One request → sample_o=word0, level_o=15, push_ready_o=1 on the next cycle.
- Request while empty, 3 times → sample_o=0, underrun_o=1, underrun_cnt_o=3. underrun_clr_i pulse → both 0. Clear plus underrun in the same cycle → flag=1, count=1.
- Empty FIFO, push and request in the same cycle → underrun_cnt_o+1, sample_o=0, level_o=1. Next request → sample_o=pushed word.
- level_o=5 with LOW_THRESHOLD=4 → low_o=0. One pop → low_o=1. flush_i with a simultaneous push → level_o=0, sample_o=0, push not stored.
- enable_i=0 with level_o=2 and a request → sample_o=0, level_o=2, underrun_cnt_o unchanged. Assert rst_n_i mid-stream → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/spdif_pkg.sv
// Shared constants for the SPDIF sample path: sample/channel widths, channel
// field positions and the mute word.
package spdif_pkg;

    localparam int SPDIF_SAMPLE_W = 32;
    localparam int SPDIF_CH_W     = 16;

    localparam int SPDIF_R_LSB = 16;
    localparam int SPDIF_L_LSB = 0;

    localparam logic [SPDIF_SAMPLE_W-1:0] SPDIF_MUTE = '0;

    function automatic logic [SPDIF_CH_W-1:0] spdif_right(input logic [SPDIF_SAMPLE_W-1:0] s);
        return s[SPDIF_R_LSB +: SPDIF_CH_W];
    endfunction

    function automatic logic [SPDIF_CH_W-1:0] spdif_left(input logic [SPDIF_SAMPLE_W-1:0] s);
        return s[SPDIF_L_LSB +: SPDIF_CH_W];
    endfunction

endpackage

// File: rtl/spdif_fifo_ram.sv
// Simple dual-port sample storage: synchronous write, asynchronous read.
// Kept separate so a vendor memory primitive can replace it.
module spdif_fifo_ram
    import spdif_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [DEPTH_LOG2-1:0]     wr_addr,
    input  logic [SPDIF_SAMPLE_W-1:0] wr_data,
    input  logic [DEPTH_LOG2-1:0]     rd_addr,
    output logic [SPDIF_SAMPLE_W-1:0] rd_data
);

    logic [SPDIF_SAMPLE_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spdif_sample_fifo.sv
// Sample FIFO feeding the SPDIF transmitter: registered next-sample word,
// mute-on-underrun with a sticky flag and saturating event counter.
module spdif_sample_fifo
    import spdif_pkg::*;
#(
    parameter int DEPTH_LOG2    = 4,
    parameter int LOW_THRESHOLD = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      enable_i,
    input  logic                      flush_i,
    input  logic                      push_valid_i,
    input  logic [SPDIF_SAMPLE_W-1:0] push_data_i,
    output logic                      push_ready_o,
    output logic [SPDIF_SAMPLE_W-1:0] sample_o,
    input  logic                      sample_req_i,
    output logic [DEPTH_LOG2:0]       level_o,
    output logic                      low_o,
    output logic                      underrun_o,
    output logic [15:0]               underrun_cnt_o,
    input  logic                      underrun_clr_i
);

    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0]   LEVEL_LOW  = (DEPTH_LOG2+1)'(LOW_THRESHOLD);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [DEPTH_LOG2-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [DEPTH_LOG2:0]       level_reg, level_next;
    logic [SPDIF_SAMPLE_W-1:0] sample_reg, sample_next;
    logic                      underrun_reg, underrun_next;
    logic [15:0]               cnt_reg, cnt_next;
    logic [15:0]               cnt_base;

    logic [SPDIF_SAMPLE_W-1:0] head_data;
    logic                      full, empty;
    logic                      push_acc, req_active, pop, underrun_ev;

    assign full  = (level_reg == LEVEL_FULL);
    assign empty = (level_reg == '0);

    // Ready comes from the registered level only: a same-cycle pop never frees a full slot.
    assign push_ready_o = !full && !flush_i;
    assign push_acc     = push_valid_i && push_ready_o;
    assign req_active   = sample_req_i && enable_i && !flush_i;
    assign pop          = req_active && !empty;
    assign underrun_ev  = req_active && empty;

    spdif_fifo_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk_i),
        .wr_en   (push_acc),
        .wr_addr (wr_ptr_reg),
        .wr_data (push_data_i),
        .rd_addr (rd_ptr_reg),
        .rd_data (head_data)
    );

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        sample_next = sample_reg;

        if (flush_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
            sample_next = SPDIF_MUTE;
        end else begin
            if (push_acc) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            if (push_acc && !pop) begin
                level_next = level_reg + LEVEL_ONE;
            end else if (!push_acc && pop) begin
                level_next = level_reg - LEVEL_ONE;
            end
            // Disabled or empty requests still consume the word, so replace it with mute.
            if (sample_req_i) begin
                sample_next = pop ? head_data : SPDIF_MUTE;
            end
        end
    end

    // Clear takes effect before the increment so a coincident underrun survives it.
    always_comb begin
        cnt_base      = underrun_clr_i ? 16'h0000 : cnt_reg;
        cnt_next      = cnt_base;
        underrun_next = underrun_clr_i ? 1'b0 : underrun_reg;
        if (underrun_ev) begin
            underrun_next = 1'b1;
            if (cnt_base != 16'hFFFF) begin
                cnt_next = cnt_base + 16'h0001;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            sample_reg   <= SPDIF_MUTE;
            underrun_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            level_reg    <= level_next;
            sample_reg   <= sample_next;
            underrun_reg <= underrun_next;
            cnt_reg      <= cnt_next;
        end
    end

    assign sample_o       = sample_reg;
    assign level_o        = level_reg;
    assign low_o          = (level_reg <= LEVEL_LOW);
    assign underrun_o     = underrun_reg;
    assign underrun_cnt_o = cnt_reg;

endmodule

// File: tb/tb_spdif_sample_fifo.sv
// Scoreboard bench for spdif_sample_fifo: a queue model of FIFO contents plus
// a queue of expected sample words checked one cycle after each request/flush.
module tb_spdif_sample_fifo;

    localparam int DEPTH  = 16;
    localparam int LOW_TH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        flush;
    logic        push_valid;
    logic [31:0] push_data;
    logic        push_ready;
    logic [31:0] sample;
    logic        sample_req;
    logic [4:0]  level;
    logic        low;
    logic        underrun;
    logic [15:0] underrun_cnt;
    logic        underrun_clr;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_q[$];
    logic [31:0] exp_q[$];
    logic        m_flag;
    int          m_cnt;

    always #5 clk = ~clk;

    spdif_sample_fifo #(
        .DEPTH_LOG2    (4),
        .LOW_THRESHOLD (LOW_TH)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .enable_i       (enable),
        .flush_i        (flush),
        .push_valid_i   (push_valid),
        .push_data_i    (push_data),
        .push_ready_o   (push_ready),
        .sample_o       (sample),
        .sample_req_i   (sample_req),
        .level_o        (level),
        .low_o          (low),
        .underrun_o     (underrun),
        .underrun_cnt_o (underrun_cnt),
        .underrun_clr_i (underrun_clr)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check_val({tag, ".level"}, 32'(level), 32'(m_q.size()));
        check_val({tag, ".low"}, 32'(low), 32'(m_q.size() <= LOW_TH));
        check_val({tag, ".underrun"}, 32'(underrun), 32'(m_flag));
        check_val({tag, ".cnt"}, 32'(underrun_cnt), 32'(m_cnt));
    endtask

    // One clock of stimulus, called just after a falling edge.
    task automatic step(input bit v, input logic [31:0] d, input bit req,
                        input bit en, input bit fl, input bit clr);
        bit          rdy;
        bit          acc;
        bit          rp;
        logic [31:0] s;
        push_valid   = v;
        push_data    = d;
        sample_req   = req;
        enable       = en;
        flush        = fl;
        underrun_clr = clr;
        #1;
        rdy = (m_q.size() < DEPTH) && !fl;
        check_val("push_ready", 32'(push_ready), 32'(rdy));
        acc = v && rdy;
        rp  = req && en && !fl;
        if (clr) begin
            m_flag = 1'b0;
            m_cnt  = 0;
        end
        if (fl) begin
            m_q.delete();
            exp_q.push_back(32'h0);
        end else begin
            if (req) begin
                s = 32'h0;
                if (rp && m_q.size() > 0) begin
                    s = m_q.pop_front();
                end else if (rp) begin
                    m_flag = 1'b1;
                    if (m_cnt < 16'hFFFF) m_cnt++;
                end
                exp_q.push_back(s);
            end
            if (acc) m_q.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
        push_valid   = 1'b0;
        sample_req   = 1'b0;
        flush        = 1'b0;
        underrun_clr = 1'b0;
        enable       = 1'b1;
        $display("txn v=%0b d=%h req=%0b en=%0b fl=%0b clr=%0b -> sample=%h level=%0d low=%0b ur=%0b cnt=%0d",
                 v, d, req, en, fl, clr, sample, level, low, underrun, underrun_cnt);
        check_state("step");
        if (exp_q.size() > 0) begin
            check_val("sample", sample, exp_q.pop_front());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ".level"}, 32'(level), 32'h0);
        check_val({tag, ".sample"}, sample, 32'h0);
        check_val({tag, ".ready"}, 32'(push_ready), 32'h1);
        check_val({tag, ".low"}, 32'(low), 32'h1);
        check_val({tag, ".underrun"}, 32'(underrun), 32'h0);
        check_val({tag, ".cnt"}, 32'(underrun_cnt), 32'h0);
    endtask

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b1;
        flush        = 1'b0;
        push_valid   = 1'b0;
        push_data    = 32'h0;
        sample_req   = 1'b0;
        underrun_clr = 1'b0;
        m_flag       = 1'b0;
        m_cnt        = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // Basic fill and drain
        for (int i = 1; i <= 3; i++) step(1, 32'h1111_0000 + 32'(i), 0, 1, 0, 0);
        check_val("fill3.sample", sample, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 1, 0, 0);

        // Fill to full, refused 17th push, then one pop and back-to-back drain
        for (int i = 0; i < 16; i++) step(1, 32'h2222_0000 + 32'(i), 0, 1, 0, 0);
        step(1, 32'h2222_00FF, 0, 1, 0, 0);
        step(0, 32'h0, 1, 1, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 32'h0, 1, 1, 0, 0);

        // Underruns, clear, and clear coinciding with an underrun
        for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 1, 0, 0);
        check_val("ur3.cnt", 32'(underrun_cnt), 32'd3);
        step(0, 32'h0, 0, 1, 0, 1);
        step(0, 32'h0, 1, 1, 0, 1);
        check_val("clr_ur.cnt", 32'(underrun_cnt), 32'd1);

        // Push and request together while empty: underrun, word still stored
        step(1, 32'h3333_ABCD, 1, 1, 0, 0);
        step(0, 32'h0, 1, 1, 0, 0);

        // Low watermark and flush with a simultaneous push
        for (int i = 0; i < 5; i++) step(1, 32'h4444_0000 + 32'(i), 0, 1, 0, 0);
        step(0, 32'h0, 1, 1, 0, 0);
        step(1, 32'h4444_00EE, 0, 1, 1, 0);

        // Disabled request mutes without popping
        step(1, 32'h5555_0001, 0, 1, 0, 0);
        step(1, 32'h5555_0002, 0, 1, 0, 0);
        step(0, 32'h0, 1, 1, 0, 0);
        step(1, 32'h5555_0003, 0, 1, 0, 0);
        step(0, 32'h0, 1, 0, 0, 0);
        step(0, 32'h0, 1, 1, 0, 0);

        // Asynchronous reset mid-stream, away from any clock edge
        step(0, 32'h0, 0, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        m_q.delete();
        exp_q.delete();
        m_flag = 1'b0;
        m_cnt  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 32'h6666_0001, 0, 1, 0, 0);
        step(0, 32'h0, 1, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
